bullet_hit_detector: RTL and testbench

- Sits directly downstream of the bullet block and consumes its bullet_x/bullet_y/bullet_state outputs.
- Once per frame it scans the alien grid one alien per clock. It reports the first live alien whose box overlaps the bullet box.
- On a hit it drives the bullet block's active-low reset so the bullet returns to IDLE.
- It also emits hit_idx so the alien manager can clear that alien's alive bit.

---
 rtl/bullet_hit_detector.sv | 145 ++++++++++++++
 tb/tb_bullet_hit_detector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bullet_hit_detector.sv
// Per-frame bullet/alien collision scan: walks the alien grid one alien per clock
// and reports the lowest-index live alien whose hitbox overlaps the bullet.
module bullet_hit_detector #(
  parameter int unsigned SCREEN_CORDW = 16,
  parameter int unsigned ALIEN_ROWS   = 5,
  parameter int unsigned ALIEN_COLS   = 11,
  parameter int unsigned ALIEN_W      = 24,
  parameter int unsigned ALIEN_H      = 16,
  parameter int unsigned PITCH_X      = 32,
  parameter int unsigned PITCH_Y      = 24,
  parameter int unsigned BULLET_W     = 39,
  parameter int unsigned BULLET_H     = 24,
  localparam int unsigned N           = ALIEN_ROWS * ALIEN_COLS,
  localparam int unsigned IW          = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame,
  input  logic                           bullet_active,
  input  logic signed [SCREEN_CORDW-1:0] bullet_x,
  input  logic signed [SCREEN_CORDW-1:0] bullet_y,
  input  logic signed [SCREEN_CORDW-1:0] grid_x,
  input  logic signed [SCREEN_CORDW-1:0] grid_y,
  input  logic        [N-1:0]            alive,
  output logic                           bullet_rst,
  output logic                           hit,
  output logic        [IW-1:0]           hit_idx,
  output logic                           busy
);

  localparam int unsigned AW = SCREEN_CORDW + 1;
  localparam int unsigned CW = (ALIEN_COLS > 1) ? $clog2(ALIEN_COLS) : 1;

  localparam logic signed [AW-1:0] ALIEN_W_S  = AW'(ALIEN_W);
  localparam logic signed [AW-1:0] ALIEN_H_S  = AW'(ALIEN_H);
  localparam logic signed [AW-1:0] BULLET_W_S = AW'(BULLET_W);
  localparam logic signed [AW-1:0] BULLET_H_S = AW'(BULLET_H);
  localparam logic signed [AW-1:0] PITCH_X_S  = AW'(PITCH_X);
  localparam logic signed [AW-1:0] PITCH_Y_S  = AW'(PITCH_Y);
  localparam logic [CW-1:0]        COL_LAST   = CW'(ALIEN_COLS - 1);
  localparam logic [IW-1:0]        IDX_LAST   = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HIT
  } state_t;

  state_t state, state_next;

  logic signed [AW-1:0] bx_s, by_s, gx_s;
  logic signed [AW-1:0] ax, ay;
  logic        [N-1:0]  alive_s;
  logic        [CW-1:0] col;
  logic        [IW-1:0] idx;

  logic overlap_c;
  logic load_c;
  logic advance_c;

  // Strict box-overlap test against the current alien, all at AW-bit signed width.
  assign overlap_c = (bx_s < ax + ALIEN_W_S) && (ax < bx_s + BULLET_W_S) &&
                     (by_s < ay + ALIEN_H_S) && (ay < by_s + BULLET_H_S);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    advance_c  = 1'b0;
    case (state)
      IDLE: begin
        if (frame && bullet_active) begin
          load_c     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // A bullet that left the screen mid-scan can no longer score.
        if (!bullet_active) begin
          state_next = IDLE;
        end else if (alive_s[idx] && overlap_c) begin
          state_next = HIT;
        end else if (idx == IDX_LAST) begin
          state_next = IDLE;
        end else begin
          advance_c = 1'b1;
        end
      end
      HIT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot and grid-walk accumulators; ax/ay track the current alien origin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bx_s    <= '0;
      by_s    <= '0;
      gx_s    <= '0;
      ax      <= '0;
      ay      <= '0;
      alive_s <= '0;
      col     <= '0;
      idx     <= '0;
    end else if (load_c) begin
      bx_s    <= {bullet_x[SCREEN_CORDW-1], bullet_x};
      by_s    <= {bullet_y[SCREEN_CORDW-1], bullet_y};
      gx_s    <= {grid_x[SCREEN_CORDW-1], grid_x};
      ax      <= {grid_x[SCREEN_CORDW-1], grid_x};
      ay      <= {grid_y[SCREEN_CORDW-1], grid_y};
      alive_s <= alive;
      col     <= '0;
      idx     <= '0;
    end else if (advance_c) begin
      idx <= idx + IW'(1);
      if (col == COL_LAST) begin
        col <= '0;
        ax  <= gx_s;
        ay  <= ay + PITCH_Y_S;
      end else begin
        col <= col + CW'(1);
        ax  <= ax + PITCH_X_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit        <= 1'b0;
      bullet_rst <= 1'b1;
      hit_idx    <= '0;
      busy       <= 1'b0;
    end else begin
      hit        <= (state_next == HIT);
      bullet_rst <= (state_next != HIT);
      busy       <= (state_next != IDLE);
      if (state == SCAN && state_next == HIT) hit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Directed bench for bullet_hit_detector: a direct-formula collision model fills a
// per-cycle expectation queue that is popped and checked after every clock.
module tb_bullet_hit_detector;

  localparam int unsigned N  = 55;
  localparam int unsigned IW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame;
  logic                 bullet_active;
  logic signed [15:0]   bullet_x, bullet_y, grid_x, grid_y;
  logic        [N-1:0]  alive;
  logic                 bullet_rst, hit, busy;
  logic        [IW-1:0] hit_idx;

  typedef struct {
    logic          hit;
    logic          brst;
    logic          busy;
    logic          idx_chk;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   k;
  logic [N-1:0] al;

  always #5 clk = ~clk;

  bullet_hit_detector dut (
    .clk(clk), .rst(rst), .frame(frame), .bullet_active(bullet_active),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .grid_x(grid_x), .grid_y(grid_y),
    .alive(alive), .bullet_rst(bullet_rst), .hit(hit), .hit_idx(hit_idx), .busy(busy)
  );

  // Lowest live overlapping alien index, or -1, straight from the geometry.
  function automatic int model_hit(int bx, int by, int gx, int gy, logic [N-1:0] alv);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 11; c++) begin
        int ax, ay, i;
        i  = r * 11 + c;
        ax = gx + c * 32;
        ay = gy + r * 24;
        if (alv[i] && bx < ax + 24 && ax < bx + 39 && by < ay + 16 && ay < by + 24)
          return i;
      end
    end
    return -1;
  endfunction

  // Expected outputs for cycles 1..ncyc after a trigger; from cycle 'cut' on, idle.
  task automatic push_scan(input int kh, input int ncyc, input int cut);
    for (int c = 1; c <= ncyc; c++) begin
      exp_t e;
      if (kh >= 0) begin
        e.busy = (c <= kh + 2);
        e.hit  = (c == kh + 2);
      end else begin
        e.busy = (c <= int'(N));
        e.hit  = 1'b0;
      end
      if (cut > 0 && c >= cut) begin
        e.busy = 1'b0;
        e.hit  = 1'b0;
      end
      e.brst    = ~e.hit;
      e.idx_chk = e.hit;
      e.idx     = IW'(kh);
      q.push_back(e);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_idx(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    frame = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      step();
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
        e = q.pop_front();
        check_bit({tag, "_busy"}, busy, e.busy);
        check_bit({tag, "_hit"}, hit, e.hit);
        check_bit({tag, "_bullet_rst"}, bullet_rst, e.brst);
        if (e.idx_chk) check_idx({tag, "_hit_idx"}, hit_idx, e.idx);
      end
    end
  endtask

  task automatic start(input int bx, input int by, input int gx, input int gy, input logic [N-1:0] alv);
    bullet_x      = 16'(bx);
    bullet_y      = 16'(by);
    grid_x        = 16'(gx);
    grid_y        = 16'(gy);
    alive         = alv;
    bullet_active = 1'b1;
    frame         = 1'b1;
  endtask

  initial begin
    rst = 1'b0; frame = 1'b0; bullet_active = 1'b0;
    bullet_x = '0; bullet_y = '0; grid_x = '0; grid_y = '0; alive = '0;
    step();
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_hit", hit, 1'b0);
    check_bit("reset_bullet_rst", bullet_rst, 1'b1);
    check_idx("reset_hit_idx", hit_idx, '0);
    rst = 1'b1;
    step();

    // Hit on alien 0 at cycle 2
    al = '1;
    start(95, 60, 100, 50, al);
    k = model_hit(95, 60, 100, 50, al);
    push_scan(k, 60, 0);
    run(60, "s1");

    // Row 2 col 3, hit in cycle 27
    start(196, 98, 100, 50, al);
    k = model_hit(196, 98, 100, 50, al);
    push_scan(k, 60, 0);
    run(60, "s2");

    // Target dead (and its right neighbour, which the bullet also overlaps): full scan
    al = '1; al[25] = 1'b0; al[26] = 1'b0;
    start(196, 98, 100, 50, al);
    k = model_hit(196, 98, 100, 50, al);
    push_scan(k, 60, 0);
    run(60, "s3");

    // Edge-touching bullet against the only live alien, then one pixel inside
    al = '0; al[0] = 1'b1;
    start(124, 60, 100, 50, al);
    k = model_hit(124, 60, 100, 50, al);
    push_scan(k, 60, 0);
    run(60, "s4_touch");
    start(123, 60, 100, 50, al);
    k = model_hit(123, 60, 100, 50, al);
    push_scan(k, 60, 0);
    run(60, "s4_inside");

    // Reset mid-scan abandons it
    al = '1;
    start(196, 98, 100, 50, al);
    k = model_hit(196, 98, 100, 50, al);
    push_scan(k, 60, 11);
    run(10, "s5");
    rst = 1'b0;
    run(1, "s5_rst");
    rst = 1'b1;
    run(49, "s5_after");

    // Inputs changed and frame re-pulsed mid-scan: snapshot wins, no re-trigger
    start(196, 98, 100, 50, al);
    k = model_hit(196, 98, 100, 50, al);
    push_scan(k, 60, 0);
    run(3, "s6");
    alive  = '0;
    grid_x = 16'(0);
    run(2, "s6");
    frame = 1'b1;
    run(55, "s6_refire");

    // Bullet leaves the screen mid-scan
    start(196, 98, 100, 50, al);
    k = model_hit(196, 98, 100, 50, al);
    push_scan(k, 60, 11);
    run(10, "s7");
    bullet_active = 1'b0;
    run(50, "s7_abort");

    // Frame with no active bullet stays idle
    start(95, 60, 100, 50, al);
    bullet_active = 1'b0;
    push_scan(-1, 10, 1);
    run(10, "s8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
